// File: rtl/pool_relu.sv
// pool_relu: 2x2 stride-2 max-pooling stage behind the conv engine.
//
// An ICB master that walks a CHN x DIM x DIM signed int8 map at IN_ADDR and
// writes the CHN x DIM/2 x DIM/2 pooled map to OUT_ADDR. Each output word
// costs four reads (A,B = row 2r, words 2k/2k+1; C,D = row 2r+1, same words)
// followed by one write. Exactly one ICB transaction is outstanding at a time.
//
// Optional build macro: POOL_RELU_EN -- when defined, negative pooled bytes
// are written as 8'h00; otherwise the raw signed maximum is written.
//
// Ports:
//   clk                 clock
//   rst_n               synchronous reset, ACTIVE-HIGH despite the name
//   pool_icb_cmd_valid  command valid (high exactly in RCMD/WCMD)
//   pool_icb_cmd_ready  command ready from the fabric
//   pool_icb_cmd_addr   byte address
//   pool_icb_cmd_read   1 = read, 0 = write
//   pool_icb_cmd_wdata  pooled output word
//   pool_icb_cmd_wmask  byte mask, always 4'b1111
//   pool_icb_rsp_valid  response valid
//   pool_icb_rsp_ready  always 1
//   pool_icb_rsp_rdata  read data (ignored for write responses)
//   start               level input; a rising edge in IDLE launches a run
//   done                sticky completion flag, cleared by the next accepted start
module pool_relu #(
  parameter logic [31:0] IN_ADDR  = 32'h6000_0000,
  parameter logic [31:0] OUT_ADDR = 32'h7000_0000,
  parameter int          CHN      = 16,
  parameter int          DIM      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pool_icb_cmd_valid,
  input  logic        pool_icb_cmd_ready,
  output logic [31:0] pool_icb_cmd_addr,
  output logic        pool_icb_cmd_read,
  output logic [31:0] pool_icb_cmd_wdata,
  output logic [3:0]  pool_icb_cmd_wmask,
  input  logic        pool_icb_rsp_valid,
  output logic        pool_icb_rsp_ready,
  input  logic [31:0] pool_icb_rsp_rdata,
  input  logic        start,
  output logic        done
);

  localparam int KN = DIM / 8;   // output words per pooled row
  localparam int RN = DIM / 2;   // pooled rows per channel
  localparam int KW = (KN > 1) ? $clog2(KN) : 1;
  localparam int RW = (RN > 1) ? $clog2(RN) : 1;
  localparam int CW = (CHN > 1) ? $clog2(CHN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RCMD, S_RRSP, S_WCMD, S_WRSP} state_e;

  state_e state_q, state_d;

  logic              start_q;
  logic              start_rise;
  logic              done_q;
  logic [1:0]        rd_q;      // which of A/B/C/D is in flight
  logic [KW-1:0]     k_q;
  logic [RW-1:0]     r_q;
  logic [CW-1:0]     ch_q;
  logic [3:0][7:0]   mx_q;      // running signed max, one per output byte

  logic              k_last, r_last, ch_last, last_word;
  logic [RW:0]       in_row;
  logic [KW:0]       in_word;
  logic [31:0]       in_idx, out_idx;
  logic signed [7:0] lo_max, hi_max;
  logic [31:0]       pool_word;

  function automatic logic signed [7:0] smax(input logic signed [7:0] a,
                                             input logic signed [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Final write mux; the compare path is the same with or without ReLU.
  function automatic logic [7:0] relu(input logic signed [7:0] v);
`ifdef POOL_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  assign start_rise = start & ~start_q;

  assign k_last    = (k_q  == KW'(KN - 1));
  assign r_last    = (r_q  == RW'(RN - 1));
  assign ch_last   = (ch_q == CW'(CHN - 1));
  assign last_word = k_last & r_last & ch_last;

  // rd_q[1] selects the second input row (C/D), rd_q[0] the odd word (B/D).
  assign in_row  = {r_q, rd_q[1]};
  assign in_word = {k_q, rd_q[0]};
  assign in_idx  = 32'(ch_q) * 32'(DIM * DIM / 4) + 32'(in_row) * 32'(DIM / 4)
                 + 32'(in_word);
  assign out_idx = 32'(ch_q) * 32'(DIM * DIM / 16) + 32'(r_q) * 32'(KN)
                 + 32'(k_q);

  // Each read word feeds two output bytes: bytes 0/1 pair up, bytes 2/3 pair up.
  assign lo_max = smax(pool_icb_rsp_rdata[7:0],   pool_icb_rsp_rdata[15:8]);
  assign hi_max = smax(pool_icb_rsp_rdata[23:16], pool_icb_rsp_rdata[31:24]);

  assign pool_word = {relu(mx_q[3]), relu(mx_q[2]), relu(mx_q[1]), relu(mx_q[0])};

  always_ff @(posedge clk) begin
    if (rst_n) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_rise)         state_d = S_RCMD;
      S_RCMD: if (pool_icb_cmd_ready) state_d = S_RRSP;
      S_RRSP: if (pool_icb_rsp_valid) state_d = (rd_q == 2'd3) ? S_WCMD : S_RCMD;
      S_WCMD: if (pool_icb_cmd_ready) state_d = S_WRSP;
      S_WRSP: if (pool_icb_rsp_valid) state_d = last_word ? S_IDLE : S_RCMD;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so they hold steady while stalled.
  always_comb begin
    pool_icb_cmd_valid = 1'b0;
    pool_icb_cmd_read  = 1'b0;
    pool_icb_cmd_addr  = 32'h0;
    pool_icb_cmd_wdata = 32'h0;
    unique case (state_q)
      S_RCMD: begin
        pool_icb_cmd_valid = 1'b1;
        pool_icb_cmd_read  = 1'b1;
        pool_icb_cmd_addr  = IN_ADDR + (in_idx << 2);
      end
      S_WCMD: begin
        pool_icb_cmd_valid = 1'b1;
        pool_icb_cmd_addr  = OUT_ADDR + (out_idx << 2);
        pool_icb_cmd_wdata = pool_word;
      end
      default: ;
    endcase
  end

  assign pool_icb_cmd_wmask = 4'b1111;
  assign pool_icb_rsp_ready = 1'b1;
  assign done               = done_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 2'd0;
      k_q     <= '0;
      r_q     <= '0;
      ch_q    <= '0;
      mx_q    <= '0;
    end else begin
      start_q <= start;
      unique case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            done_q <= 1'b0;
            rd_q   <= 2'd0;
            k_q    <= '0;
            r_q    <= '0;
            ch_q   <= '0;
          end
        end
        S_RRSP: begin
          if (pool_icb_rsp_valid) begin
            rd_q <= rd_q + 2'd1;
            unique case (rd_q)
              2'd0: begin mx_q[0] <= lo_max; mx_q[1] <= hi_max; end
              2'd1: begin mx_q[2] <= lo_max; mx_q[3] <= hi_max; end
              2'd2: begin
                mx_q[0] <= smax(mx_q[0], lo_max);
                mx_q[1] <= smax(mx_q[1], hi_max);
              end
              default: begin
                mx_q[2] <= smax(mx_q[2], lo_max);
                mx_q[3] <= smax(mx_q[3], hi_max);
              end
            endcase
          end
        end
        S_WRSP: begin
          if (pool_icb_rsp_valid) begin
            if (last_word) begin
              done_q <= 1'b1;
            end else if (k_last) begin
              k_q <= '0;
              if (r_last) begin
                r_q  <= '0;
                ch_q <= ch_q + 1'b1;
              end else begin
                r_q <= r_q + 1'b1;
              end
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_relu.sv
module tb_pool_relu;

  localparam int          CHN      = 16;
  localparam int          DIM      = 32;
  localparam int          NWORD    = CHN * DIM * DIM / 16;
  localparam int          NTXN     = NWORD * 5;
  localparam logic [31:0] IN_ADDR  = 32'h6000_0000;
  localparam logic [31:0] OUT_ADDR = 32'h7000_0000;
`ifdef POOL_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        pool_icb_cmd_valid;
  logic        pool_icb_cmd_ready;
  logic [31:0] pool_icb_cmd_addr;
  logic        pool_icb_cmd_read;
  logic [31:0] pool_icb_cmd_wdata;
  logic [3:0]  pool_icb_cmd_wmask;
  logic        pool_icb_rsp_valid;
  logic        pool_icb_rsp_ready;
  logic [31:0] pool_icb_rsp_rdata;
  logic        start;
  logic        done;

  pool_relu dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pool_icb_cmd_valid (pool_icb_cmd_valid),
    .pool_icb_cmd_ready (pool_icb_cmd_ready),
    .pool_icb_cmd_addr  (pool_icb_cmd_addr),
    .pool_icb_cmd_read  (pool_icb_cmd_read),
    .pool_icb_cmd_wdata (pool_icb_cmd_wdata),
    .pool_icb_cmd_wmask (pool_icb_cmd_wmask),
    .pool_icb_rsp_valid (pool_icb_rsp_valid),
    .pool_icb_rsp_ready (pool_icb_rsp_ready),
    .pool_icb_rsp_rdata (pool_icb_rsp_rdata),
    .start              (start),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  inmap [CHN*DIM*DIM];
  logic [31:0] lit_addr [5];

  int nchk = 0;
  int nerr = 0;
  int n, nwr, nrd, t, dly, run_id;
  bit zw, timed, run_on, done_seen, rst_arm, rst_fired;
  bit pending, pend_read, prev_valid, prev_hs, prev_read, hs;
  logic [31:0] pend_addr, prev_addr, prev_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d, txn %0d)", name, act, exp, t, n);
    end
  endtask

  function automatic logic signed [7:0] pix(input int ch, input int row, input int col);
    return inmap[ch*DIM*DIM + row*DIM + col];
  endfunction

  // Reference: pooled word w = four adjacent output pixels, each the max of its 2x2 window.
  function automatic logic [31:0] model_word(input int w);
    int ch, rem, r, k, c;
    logic signed [7:0] m, p;
    logic [31:0] res;
    ch  = w / (DIM*DIM/16);
    rem = w % (DIM*DIM/16);
    r   = rem / (DIM/8);
    k   = rem % (DIM/8);
    res = '0;
    for (int j = 0; j < 4; j++) begin
      c = 4*k + j;
      m = pix(ch, 2*r, 2*c);
      for (int q = 1; q < 4; q++) begin
        p = pix(ch, 2*r + q/2, 2*c + q%2);
        if (p > m) m = p;
      end
      if (RELU && m < 0) m = 8'sd0;
      res[8*j +: 8] = m;
    end
    return res;
  endfunction

  function automatic logic [31:0] exp_addr(input int nn);
    int w, s, ch, rem, r, k, row, wd;
    w = nn / 5;
    s = nn % 5;
    if (s == 4) return OUT_ADDR + 32'(4*w);
    ch  = w / (DIM*DIM/16);
    rem = w % (DIM*DIM/16);
    r   = rem / (DIM/8);
    k   = rem % (DIM/8);
    row = 2*r + s/2;
    wd  = 2*k + s%2;
    return IN_ADDR + 32'(4*(ch*DIM*DIM/4 + row*DIM/4 + wd));
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] addr);
    int idx;
    idx = int'((addr - IN_ADDR) >> 2);
    if (addr < IN_ADDR || idx >= CHN*DIM*DIM/4) return 32'hDEAD_BEEF;
    return {inmap[4*idx+3], inmap[4*idx+2], inmap[4*idx+1], inmap[4*idx]};
  endfunction

  // One clock of the ICB slave plus all per-cycle checks, run at the falling edge.
  task automatic cyc();
    @(negedge clk);
    t++;
    if (rst_n) begin
      chk("post_reset_valid", 32'(pool_icb_cmd_valid), 32'd0);
      chk("post_reset_done",  32'(done), 32'd0);
      chk("post_reset_addr",  pool_icb_cmd_addr, 32'd0);
      rst_n     = 1'b0;
      rst_fired = 1'b1;
      return;
    end
    if (pool_icb_rsp_valid) begin
      pool_icb_rsp_valid = 1'b0;
      pending = 1'b0;
    end
    if (prev_valid && !prev_hs) begin
      chk("valid_held",   32'(pool_icb_cmd_valid), 32'd1);
      chk("addr_stable",  pool_icb_cmd_addr, prev_addr);
      chk("read_stable",  32'(pool_icb_cmd_read), 32'(prev_read));
      chk("wdata_stable", pool_icb_cmd_wdata, prev_wdata);
    end
    if (run_on && done && !done_seen) begin
      done_seen = 1'b1;
      run_on    = 1'b0;
      chk("txns_at_done", 32'(n), 32'(NTXN));
      if (timed) chk("done_latency", 32'(t), 32'd10241);
    end
    if (pending) begin
      if (dly == 0) begin
        pool_icb_rsp_valid = 1'b1;
        pool_icb_rsp_rdata = pend_read ? rd_word(pend_addr) : $urandom();
      end else begin
        dly--;
      end
    end
    pool_icb_cmd_ready = zw ? 1'b1 : ($urandom_range(0, 2) != 0);
    if (rst_arm && pool_icb_cmd_valid && !pool_icb_cmd_read && nwr == 299) begin
      rst_n = 1'b1;
      start = 1'b0;
      rst_arm = 1'b0;
      pool_icb_cmd_ready = 1'b0;
      pool_icb_rsp_valid = 1'b0;
      pending = 1'b0;
      prev_valid = 1'b0;
      prev_hs = 1'b0;
      run_on = 1'b0;
      n = NTXN;
      return;
    end
    hs = pool_icb_cmd_valid && pool_icb_cmd_ready;
    if (hs) begin
      if (n >= NTXN) begin
        chk("no_cmd_when_idle", 32'(pool_icb_cmd_valid), 32'd0);
      end else begin
        chk("cmd_addr", pool_icb_cmd_addr, exp_addr(n));
        chk("cmd_read", 32'(pool_icb_cmd_read), 32'((n % 5) != 4));
        if (n < 5) chk("first_addr_lit", pool_icb_cmd_addr, lit_addr[n]);
        if (n == NTXN - 1) chk("last_addr_lit", pool_icb_cmd_addr, 32'h7000_0FFC);
        if (!pool_icb_cmd_read) begin
          chk("wmask", 32'(pool_icb_cmd_wmask), 32'hF);
          chk("wdata_model", pool_icb_cmd_wdata, model_word(n / 5));
          if (run_id == 1 && nwr == 0)
            chk("first_write_lit", pool_icb_cmd_wdata, RELU ? 32'h0000_0806 : 32'h8080_0806);
          if (run_id == 1 && nwr == 1)
            chk("mixed_sign_lit", pool_icb_cmd_wdata, RELU ? 32'h0000_007F : 32'h0000_FE7F);
          nwr++;
        end else begin
          nrd++;
        end
        n++;
      end
      pending   = 1'b1;
      pend_read = pool_icb_cmd_read;
      pend_addr = pool_icb_cmd_addr;
      dly       = zw ? 0 : int'($urandom_range(0, 5));
    end
    prev_valid = pool_icb_cmd_valid;
    prev_hs    = hs;
    prev_addr  = pool_icb_cmd_addr;
    prev_read  = pool_icb_cmd_read;
    prev_wdata = pool_icb_cmd_wdata;
  endtask

  task automatic begin_run(input bit z, input bit tm, input int id);
    zw = z; timed = tm; run_id = id;
    n = 0; nwr = 0; nrd = 0; t = 0;
    done_seen = 1'b0; run_on = 1'b1;
    start = 1'b1;
  endtask

  task automatic end_run(input string name, input int budget);
    while (!done_seen && t < budget) cyc();
    if (!done_seen) begin
      nchk++;
      nerr++;
      $display("FAIL %s_done_timeout: done still %0b after %0d cycles", name, done, budget);
    end else begin
      chk("write_count", 32'(nwr), 32'(NWORD));
      chk("read_count",  32'(nrd), 32'(4*NWORD));
    end
  endtask

  task automatic set_px(input int row, input int col, input logic [7:0] v);
    inmap[row*DIM + col] = v;
  endtask

  initial begin
    lit_addr[0] = 32'h6000_0000;
    lit_addr[1] = 32'h6000_0004;
    lit_addr[2] = 32'h6000_0020;
    lit_addr[3] = 32'h6000_0024;
    lit_addr[4] = 32'h7000_0000;
    rst_n = 1'b1;
    start = 1'b0;
    pool_icb_cmd_ready = 1'b0;
    pool_icb_rsp_valid = 1'b0;
    pool_icb_rsp_rdata = 32'h0;
    n = NTXN; nwr = 0; nrd = 0; t = 0; dly = 0; run_id = 0;
    zw = 1'b1; timed = 1'b0; run_on = 1'b0; done_seen = 1'b0;
    rst_arm = 1'b0; rst_fired = 1'b0; pending = 1'b0;
    prev_valid = 1'b0; prev_hs = 1'b0; prev_read = 1'b0; hs = 1'b0;
    pend_read = 1'b0; pend_addr = '0; prev_addr = '0; prev_wdata = '0;

    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(pool_icb_cmd_valid), 32'd0);
    chk("reset_read",  32'(pool_icb_cmd_read), 32'd0);
    chk("reset_addr",  pool_icb_cmd_addr, 32'd0);
    chk("reset_wdata", pool_icb_cmd_wdata, 32'd0);
    chk("reset_done",  32'(done), 32'd0);
    chk("rsp_ready",   32'(pool_icb_rsp_ready), 32'd1);
    rst_n = 1'b0;

    // Directed map: sign/order pattern in the first window, mixed signs in the second.
    for (int i = 0; i < CHN*DIM*DIM; i++) inmap[i] = 8'(i*37 + 11);
    for (int c = 0; c < 4; c++) begin
      set_px(0, c, 8'(c + 1));
      set_px(1, c, 8'(c + 5));
      set_px(0, c + 4, 8'h80);
      set_px(1, c + 4, 8'h80);
      set_px(0, c + 12, 8'h00);
      set_px(1, c + 12, 8'h00);
    end
    set_px(0, 8, 8'hFF); set_px(0, 9, 8'h80); set_px(0, 10, 8'hFD); set_px(0, 11, 8'hF9);
    set_px(1, 8, 8'h7F); set_px(1, 9, 8'hFB); set_px(1, 10, 8'h80); set_px(1, 11, 8'hFE);
    chk("model_pin_w0", model_word(0), RELU ? 32'h0000_0806 : 32'h8080_0806);
    chk("model_pin_w1", model_word(1), RELU ? 32'h0000_007F : 32'h0000_FE7F);

    repeat (3) cyc();

    // Run 1: zero-wait slave, start toggled mid-run and then held high past done.
    begin_run(1'b1, 1'b1, 1);
    while (!done_seen && t < 12000) begin
      cyc();
      if (t == 500)      start = 1'b0;
      else if (t == 600) start = 1'b1;
      else if (t == 700) start = 1'b0;
      else if (t == 800) start = 1'b1;
    end
    end_run("run1", 12000);
    repeat (40) begin
      cyc();
      chk("idle_no_valid", 32'(pool_icb_cmd_valid), 32'd0);
      chk("done_sticky",   32'(done), 32'd1);
    end

    // Run 2: random map, random ready stalls and response delays.
    start = 1'b0;
    cyc();
    for (int i = 0; i < CHN*DIM*DIM; i++) inmap[i] = 8'($urandom());
    begin_run(1'b0, 1'b0, 2);
    cyc();
    chk("done_cleared", 32'(done), 32'd0);
    end_run("run2", 45000);

    // Run 3: reset while write #300 is being offered.
    start = 1'b0;
    cyc();
    rst_arm = 1'b1;
    rst_fired = 1'b0;
    begin_run(1'b1, 1'b0, 3);
    while (!rst_fired && t < 6000) cyc();
    if (!rst_fired) begin
      nchk++;
      nerr++;
      $display("FAIL reset_inject: write #300 not reached in %0d cycles", t);
    end
    repeat (5) begin
      cyc();
      chk("after_reset_idle", 32'(pool_icb_cmd_valid), 32'd0);
    end

    // Run 4: fresh start after the reset must redo the whole map.
    begin_run(1'b1, 1'b1, 4);
    end_run("run4", 12000);
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
